// File: rtl/cpu_isa_pkg.sv
// Shared accumulator-CPU ISA definitions: opcode map, loader states and error codes.
// Used by both the program loader and the instruction decoder.
package cpu_isa_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned N_MNEM = 11;

    localparam logic [OPC_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OPC_W-1:0] OP_STA = 4'b0001;
    localparam logic [OPC_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OPC_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OPC_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OPC_W-1:0] OP_INC = 4'b0110;
    localparam logic [OPC_W-1:0] OP_CLR = 4'b0111;
    localparam logic [OPC_W-1:0] OP_JMP = 4'b1000;
    localparam logic [OPC_W-1:0] OP_JPZ = 4'b1100;
    localparam logic [OPC_W-1:0] OP_JPN = 4'b1001;
    localparam logic [OPC_W-1:0] OP_HLT = 4'b1111;

    // Bit positions of the mnemonic strobes inside the packed strobe vector
    localparam int unsigned STB_LDA = 0;
    localparam int unsigned STB_STA = 1;
    localparam int unsigned STB_ADD = 2;
    localparam int unsigned STB_SUB = 3;
    localparam int unsigned STB_XOR = 4;
    localparam int unsigned STB_INC = 5;
    localparam int unsigned STB_CLR = 6;
    localparam int unsigned STB_JMP = 7;
    localparam int unsigned STB_JPZ = 8;
    localparam int unsigned STB_JPN = 9;
    localparam int unsigned STB_HLT = 10;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LOAD,
        LD_WRITE,
        LD_DONE,
        LD_ERROR
    } ld_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_BADOP = 2'b01;
    localparam logic [1:0] ERR_OVF   = 2'b10;

endpackage

// File: rtl/op_encoder.sv
// Combinational mnemonic-strobe to opcode encoder; one_hot_o flags a legal strobe pattern.
module op_encoder
    import cpu_isa_pkg::*;
(
    input  logic [N_MNEM-1:0] strobe_i,
    output logic [OPC_W-1:0]  opcode_o,
    output logic              one_hot_o
);

    always_comb begin
        opcode_o  = OP_LDA;
        one_hot_o = 1'b1;
        case (strobe_i)
            N_MNEM'(1) << STB_LDA: opcode_o = OP_LDA;
            N_MNEM'(1) << STB_STA: opcode_o = OP_STA;
            N_MNEM'(1) << STB_ADD: opcode_o = OP_ADD;
            N_MNEM'(1) << STB_SUB: opcode_o = OP_SUB;
            N_MNEM'(1) << STB_XOR: opcode_o = OP_XOR;
            N_MNEM'(1) << STB_INC: opcode_o = OP_INC;
            N_MNEM'(1) << STB_CLR: opcode_o = OP_CLR;
            N_MNEM'(1) << STB_JMP: opcode_o = OP_JMP;
            N_MNEM'(1) << STB_JPZ: opcode_o = OP_JPZ;
            N_MNEM'(1) << STB_JPN: opcode_o = OP_JPN;
            N_MNEM'(1) << STB_HLT: opcode_o = OP_HLT;
            default:               one_hot_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// Encodes mnemonic/operand transfers into instruction words and writes them into program RAM.
// Optional running XOR checksum output is enabled with `define PROG_LOADER_CHKSUM_EN.
module prog_loader
    import cpu_isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned OPR_W  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic                   LDA,
    input  logic                   STA,
    input  logic                   ADD,
    input  logic                   SUB,
    input  logic                   XOR,
    input  logic                   INC,
    input  logic                   CLR,
    input  logic                   JMP,
    input  logic                   JPZ,
    input  logic                   JPN,
    input  logic                   HLT,
    input  logic [OPR_W-1:0]       OPERAND,
    output logic                   MEM_WE,
    output logic [ADDR_W-1:0]      MEM_ADDR,
    output logic [OPC_W+OPR_W-1:0] MEM_DATA,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [1:0]             ERR,
    output logic [ADDR_W:0]        COUNT
`ifdef PROG_LOADER_CHKSUM_EN
   ,output logic [OPC_W+OPR_W-1:0] CHKSUM
`endif
);

    localparam int unsigned WORD_W = OPC_W + OPR_W;

    ld_state_e          state_q;
    logic               in_ready_q;
    logic               mem_we_q;
    logic               busy_q;
    logic               done_q;
    logic [1:0]         err_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W:0]    count_q;
    logic [WORD_W-1:0]  word_q;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [WORD_W-1:0]  chksum_q;
`endif

    logic [OPC_W-1:0]   enc_opcode;
    logic               enc_one_hot;

    op_encoder u_op_encoder (
        .strobe_i  ({HLT, JPN, JPZ, JMP, CLR, INC, XOR, SUB, ADD, STA, LDA}),
        .opcode_o  (enc_opcode),
        .one_hot_o (enc_one_hot)
    );

    // Load-session FSM; every output except the reset-gated write strobe is a register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= LD_IDLE;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= ERR_NONE;
            addr_q     <= '0;
            count_q    <= '0;
            word_q     <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
            chksum_q   <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                LD_LOAD: begin
                    if (IN_VALID) begin
                        in_ready_q <= 1'b0;
                        if (enc_one_hot) begin
                            word_q   <= {enc_opcode, OPERAND};
                            mem_we_q <= 1'b1;
                            state_q  <= LD_WRITE;
                        end else begin
                            err_q   <= ERR_BADOP;
                            busy_q  <= 1'b0;
                            state_q <= LD_ERROR;
                        end
                    end
                end
                LD_WRITE: begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    count_q <= count_q + (ADDR_W+1)'(1);
`ifdef PROG_LOADER_CHKSUM_EN
                    chksum_q <= chksum_q ^ word_q;
`endif
                    if (word_q[WORD_W-1 -: OPC_W] == OP_HLT) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= LD_DONE;
                    end else if (addr_q == '1) begin
                        err_q   <= ERR_OVF;
                        busy_q  <= 1'b0;
                        state_q <= LD_ERROR;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= LD_LOAD;
                    end
                end
                default: begin
                    // IDLE, DONE and ERROR all accept START to open a fresh session
                    if (START) begin
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= ERR_NONE;
                        addr_q     <= '0;
                        count_q    <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
                        chksum_q   <= '0;
`endif
                        state_q    <= LD_LOAD;
                    end
                end
            endcase
        end
    end

    // Reset must be able to cancel a write already presented to the RAM in this cycle
    assign MEM_WE   = mem_we_q & ~RST;
    assign IN_READY = in_ready_q;
    assign MEM_ADDR = addr_q;
    assign MEM_DATA = word_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign COUNT    = count_q;
`ifdef PROG_LOADER_CHKSUM_EN
    assign CHKSUM   = chksum_q;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed scenarios plus randomized load sessions.
module tb_prog_loader;

    localparam int AW    = 4;
    localparam int OW    = 4;
    localparam int DW    = 4 + OW;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST, START, IN_VALID, IN_READY;
    logic [10:0]   stb;
    logic [OW-1:0] OPERAND;
    logic          MEM_WE, BUSY, DONE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DATA;
    logic [1:0]    ERR;
    logic [AW:0]   COUNT;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [DW-1:0] CHKSUM;
`endif

    always #5 CLK = ~CLK;

    prog_loader #(.ADDR_W(AW), .OPR_W(OW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .LDA(stb[0]), .STA(stb[1]), .ADD(stb[2]), .SUB(stb[3]), .XOR(stb[4]), .INC(stb[5]),
        .CLR(stb[6]), .JMP(stb[7]), .JPZ(stb[8]), .JPN(stb[9]), .HLT(stb[10]),
        .OPERAND(OPERAND), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .COUNT(COUNT)
`ifdef PROG_LOADER_CHKSUM_EN
       ,.CHKSUM(CHKSUM)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int wr_seen  = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_e;

    // Reference model of the session
    int         m_count;
    logic [DW-1:0] m_chk;
    logic [1:0] m_err;
    bit         m_done;
    bit         m_open;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [10:0] mn(input int i);
        logic [10:0] one;
        one = 11'd1;
        return one << i;
    endfunction

    // Opcode map: LDA STA ADD SUB XOR INC CLR JMP JPZ JPN HLT
    function automatic logic [3:0] opc(input int i);
        case (i)
            0: return 4'h0;  1: return 4'h1;  2: return 4'h2;  3: return 4'h3;
            4: return 4'h4;  5: return 4'h6;  6: return 4'h7;  7: return 4'h8;
            8: return 4'hC;  9: return 4'h9;  default: return 4'hF;
        endcase
    endfunction

    function automatic void model_reset();
        m_count = 0; m_chk = '0; m_err = 2'b00; m_done = 0; m_open = 1;
    endfunction

    function automatic void model_item(input logic [10:0] s, input logic [OW-1:0] opr);
        int idx;
        logic [DW-1:0] w;
        if ($countones(s) != 1) begin
            m_err = 2'b01; m_open = 0;
            return;
        end
        idx = 0;
        for (int i = 0; i < 11; i++) if (s[i]) idx = i;
        w = {opc(idx), opr};
        exp_q.push_back({AW'(m_count), w});
        m_chk ^= w;
        m_count++;
        if (idx == 10) begin
            m_done = 1; m_open = 0;
        end else if (m_count == DEPTH) begin
            m_err = 2'b10; m_open = 0;
        end
    endfunction

    // Write monitor: every MEM_WE must match the oldest expected write
    always @(negedge CLK) begin
        if (MEM_WE === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         MEM_ADDR, MEM_DATA);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(MEM_ADDR), 32'(mon_e[DW +: AW]));
                check("write_data", 32'(MEM_DATA), 32'(mon_e[DW-1:0]));
            end
        end
    end

    task automatic start_session();
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        model_reset();
        check("start_busy", 32'(BUSY), 32'd1);
        check("start_count", 32'(COUNT), 32'd0);
        check("start_err", 32'(ERR), 32'd0);
`ifdef PROG_LOADER_CHKSUM_EN
        check("start_chksum", 32'(CHKSUM), 32'd0);
`endif
    endtask

    task automatic send(input logic [10:0] s, input logic [OW-1:0] opr);
        int t;
        t = 0;
        while (IN_READY !== 1'b1 && t < 20) begin
            @(negedge CLK); t++;
        end
        if (t >= 20) begin
            n_checks++;
            $display("FAIL ready_timeout: got IN_READY=%b expected 1 within 20 cycles", IN_READY);
            m_open = 0;
            return;
        end
        model_item(s, opr);
        IN_VALID = 1'b1; stb = s; OPERAND = opr;
        @(negedge CLK);
        IN_VALID = 1'b0; stb = '0; OPERAND = OW'($urandom);
    endtask

    // Session outcome must be visible exactly one cycle after the last transfer's follow-up
    task automatic end_session(input string tag);
        @(negedge CLK);
        check({tag, "_done"}, 32'(DONE), 32'(m_done));
        check({tag, "_err"}, 32'(ERR), 32'(m_err));
        check({tag, "_count"}, 32'(COUNT), 32'(m_count));
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_ready"}, 32'(IN_READY), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
`ifdef PROG_LOADER_CHKSUM_EN
        check({tag, "_chksum"}, 32'(CHKSUM), 32'(m_chk));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(IN_READY), 32'd0);
        check({tag, "_we"}, 32'(MEM_WE), 32'd0);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_done"}, 32'(DONE), 32'd0);
        check({tag, "_err"}, 32'(ERR), 32'd0);
        check({tag, "_addr"}, 32'(MEM_ADDR), 32'd0);
        check({tag, "_data"}, 32'(MEM_DATA), 32'd0);
        check({tag, "_count"}, 32'(COUNT), 32'd0);
`ifdef PROG_LOADER_CHKSUM_EN
        check({tag, "_chksum"}, 32'(CHKSUM), 32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r;
        logic [10:0] s;
        RST = 1'b1; START = 1'b0; IN_VALID = 1'b0; stb = '0; OPERAND = '0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs("idle");

        // Four-word program ending in HLT
        start_session();
        send(mn(0), 4'd5);
        send(mn(2), 4'd6);
        send(mn(1), 4'd7);
        send(mn(10), 4'd0);
        end_session("prog4");

        // Restart from DONE, then overflow with 16 INC 3
        start_session();
        for (int i = 0; i < DEPTH; i++) send(mn(5), 4'd3);
        end_session("ovf");

        // Two strobes in one transfer
        start_session();
        send(mn(3), 4'd1);
        send(mn(0) | mn(2), 4'd2);
        check("badop_err_timing", 32'(ERR), 32'd1);
        end_session("badop");

        // IN_VALID held four cycles around a single ready window
        @(negedge CLK);
        IN_VALID = 1'b1; stb = mn(7); OPERAND = 4'd9;
        w0 = wr_seen;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        model_reset();
        model_item(mn(7), 4'd9);
        @(negedge CLK);
        check("held_ready_in_write", 32'(IN_READY), 32'd0);
        check("held_we", 32'(MEM_WE), 32'd1);
        @(negedge CLK);
        IN_VALID = 1'b0; stb = '0;
        @(negedge CLK);
        check("held_single_write", 32'(wr_seen - w0), 32'd1);
        send(mn(10), 4'd0);
        end_session("held");

        // Reset during the write cycle of CLR 0
        start_session();
        IN_VALID = 1'b1; stb = mn(6); OPERAND = 4'd0;
        @(posedge CLK);
        #1 RST = 1'b1; IN_VALID = 1'b0; stb = '0;
        @(negedge CLK);
        check("rst_we_suppressed", 32'(MEM_WE), 32'd0);
        @(negedge CLK);
        check_reset_outputs("rst_write");
        RST = 1'b0;

        // Randomized sessions with idle gaps and occasional bad encodings
        for (int sess = 0; sess < 14; sess++) begin
            start_session();
            while (m_open) begin
                repeat ($urandom_range(0, 2)) @(negedge CLK);
                r = int'($urandom_range(0, 99));
                if (r < 2) s = '0;
                else if (r < 4) begin
                    int i, j;
                    i = int'($urandom_range(0, 10));
                    j = (i + 1 + int'($urandom_range(0, 9))) % 11;
                    s = mn(i) | mn(j);
                end else if (r < 12) s = mn(10);
                else s = mn(int'($urandom_range(0, 9)));
                send(s, OW'($urandom));
            end
            end_session("rand");
        end

        repeat (3) @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
